double_threshold_hysteresis: RTL and testbench



---
 rtl/canny_pkg.sv | 30 +++
 rtl/strong_neighbor_check.sv | 30 +++
 rtl/double_threshold_hysteresis.sv | 133 +++++++++++++
 tb/tb_double_threshold_hysteresis.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny double-threshold / hysteresis stage.
package canny_pkg;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_WEAK   = 2'd1,
        CLS_STRONG = 2'd2
    } cls_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_HYST     = 2'd2,
        ST_DONE     = 2'd3
    } dth_state_t;

    localparam int EDGE_ON  = 255;
    localparam int EDGE_OFF = 0;

    // When low >= high every value passing low also passes high, so WEAK never occurs.
    function automatic cls_t classify(input int z, input int hi, input int lo);
        if (z >= hi)
            return CLS_STRONG;
        else if (z >= lo)
            return CLS_WEAK;
        else
            return CLS_NONE;
    endfunction

endpackage

// File: rtl/strong_neighbor_check.sv
// Combinational: flags whether any in-frame 8-neighbour of (row_i, col_i) is STRONG.
module strong_neighbor_check
    import canny_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5,
    parameter int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    parameter int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  cls_t          cls_i [0:HEIGHT-1][0:WIDTH-1],
    input  logic [RW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    output logic          strong_o
);

    // Scanning every cell with constant indices keeps out-of-frame neighbours implicit.
    always_comb begin
        strong_o = 1'b0;
        for (int r = 0; r < HEIGHT; r++) begin
            for (int c = 0; c < WIDTH; c++) begin
                if (cls_i[r][c] == CLS_STRONG &&
                    (r - int'(row_i)) >= -1 && (r - int'(row_i)) <= 1 &&
                    (c - int'(col_i)) >= -1 && (c - int'(col_i)) <= 1 &&
                    !(r == int'(row_i) && c == int'(col_i)))
                    strong_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/double_threshold_hysteresis.sv
// Final Canny stage: classify a snapshotted frame against two thresholds, then
// promote weak pixels touching a strong one (single pass) into a 0/255 edge map.
module double_threshold_hysteresis
    import canny_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  int   Z        [0:HEIGHT-1][0:WIDTH-1],
    input  int   high_thr,
    input  int   low_thr,
    output logic busy,
    output logic done,
    output int   edges    [0:HEIGHT-1][0:WIDTH-1]
);

    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    dth_state_t    state_q;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          last_px;
    logic          busy_q, done_q;
    logic          nb_strong;
    int            zs_q    [0:HEIGHT-1][0:WIDTH-1];
    int            hi_q, lo_q;
    cls_t          cls_q   [0:HEIGHT-1][0:WIDTH-1];
    int            edges_q [0:HEIGHT-1][0:WIDTH-1];

    always_comb begin
        last_px = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));
        row_d   = row_q;
        col_d   = col_q;
        if (last_px) begin
            row_d = '0;
            col_d = '0;
        end else if (col_q == CW'(WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end else begin
            col_d = col_q + 1'b1;
        end
    end

    strong_neighbor_check #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .RW     (RW),
        .CW     (CW)
    ) u_nb (
        .cls_i    (cls_q),
        .row_i    (row_q),
        .col_i    (col_q),
        .strong_o (nb_strong)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 0;
            lo_q    <= 0;
            for (int r = 0; r < HEIGHT; r++) begin
                for (int c = 0; c < WIDTH; c++) begin
                    zs_q[r][c]    <= 0;
                    cls_q[r][c]   <= CLS_NONE;
                    edges_q[r][c] <= EDGE_OFF;
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        zs_q    <= Z;
                        hi_q    <= high_thr;
                        lo_q    <= low_thr;
                        row_q   <= '0;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    for (int r = 0; r < HEIGHT; r++) begin
                        for (int c = 0; c < WIDTH; c++) begin
                            if (r == int'(row_q) && c == int'(col_q))
                                cls_q[r][c] <= classify(zs_q[r][c], hi_q, lo_q);
                        end
                    end
                    row_q <= row_d;
                    col_q <= col_d;
                    if (last_px)
                        state_q <= ST_HYST;
                end
                ST_HYST: begin
                    // Neighbour test reads cls_q only, so promotion never chains.
                    for (int r = 0; r < HEIGHT; r++) begin
                        for (int c = 0; c < WIDTH; c++) begin
                            if (r == int'(row_q) && c == int'(col_q))
                                edges_q[r][c] <= (cls_q[r][c] == CLS_STRONG ||
                                                  (cls_q[r][c] == CLS_WEAK && nb_strong))
                                                 ? EDGE_ON : EDGE_OFF;
                        end
                    end
                    row_q <= row_d;
                    col_q <= col_d;
                    if (last_px) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign edges = edges_q;

endmodule

// File: tb/tb_double_threshold_hysteresis.sv
// Directed bench for double_threshold_hysteresis on a 5x5 frame.
module tb_double_threshold_hysteresis;

    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;

    logic clk;
    logic rst_n;
    logic enable;
    int   zv   [0:H-1][0:W-1];
    int   hthr, lthr;
    logic busy, done;
    int   ed   [0:H-1][0:W-1];
    int   expv [0:H-1][0:W-1];

    int total = 0;
    int bad   = 0;

    double_threshold_hysteresis #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .Z        (zv),
        .high_thr (hthr),
        .low_thr  (lthr),
        .busy     (busy),
        .done     (done),
        .edges    (ed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, want);
        end
    endtask

    task automatic clear_z();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                zv[r][c] = 0;
    endtask

    task automatic clear_exp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                expv[r][c] = 0;
    endtask

    task automatic chk_edges(input string tag);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                chk($sformatf("%s_e%0d%0d", tag, r, c), ed[r][c], expv[r][c]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at edge 0, then expect done to appear right after edge 2N.
    task automatic run_frame(input string tag);
        int cyc;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        chk({tag, "_busy_acc"}, int'(busy), 1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_lat"}, cyc, 2 * N);
        chk_edges(tag);
        tick();
        chk({tag, "_done_drop"}, int'(done), 0);
        chk({tag, "_busy_drop"}, int'(busy), 0);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        rst_n  = 1'b0;
        enable = 1'b0;
        hthr   = 100;
        lthr   = 50;
        clear_z();
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_e00", ed[0][0], 0);
        rst_n = 1'b1;
        tick();

        // strong pixel promotes its weak neighbour
        clear_z();
        zv[2][2] = 120;
        zv[2][3] = 60;
        clear_exp();
        expv[2][2] = 255;
        expv[2][3] = 255;
        run_frame("t2");

        // asynchronous reset in the middle of CLASSIFY
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t1_busy", int'(busy), 0);
        chk("t1_done", int'(done), 0);
        clear_exp();
        chk_edges("t1");
        tick();
        rst_n = 1'b1;
        tick();

        // isolated weak pixel
        clear_z();
        zv[1][1] = 60;
        clear_exp();
        run_frame("t3");

        // no transitive promotion
        clear_z();
        zv[0][0] = 200;
        zv[0][1] = 60;
        zv[0][2] = 60;
        clear_exp();
        expv[0][0] = 255;
        expv[0][1] = 255;
        run_frame("t4");

        // bottom-right corner
        clear_z();
        zv[4][4] = 60;
        zv[3][3] = 150;
        clear_exp();
        expv[4][4] = 255;
        expv[3][3] = 255;
        run_frame("t5a");

        // lone weak pixel on the top edge
        clear_z();
        zv[0][4] = 60;
        clear_exp();
        run_frame("t5b");

        // negative low threshold: zeros become weak, -5 is weak too
        hthr = 100;
        lthr = -10;
        clear_z();
        zv[0][0] = 200;
        zv[1][1] = -5;
        clear_exp();
        expv[0][0] = 255;
        expv[0][1] = 255;
        expv[1][0] = 255;
        expv[1][1] = 255;
        run_frame("tneg");

        // low >= high: 90 is neither strong nor weak
        hthr = 100;
        lthr = 100;
        clear_z();
        zv[2][2] = 150;
        zv[2][1] = 90;
        clear_exp();
        expv[2][2] = 255;
        run_frame("tlohi");

        // enable held high; Z changes after accept must not leak into this frame
        hthr = 100;
        lthr = 50;
        clear_z();
        zv[2][2] = 120;
        zv[2][3] = 60;
        enable   = 1'b1;
        tick();
        busy_cnt = int'(busy);
        done_cnt = int'(done);
        for (int e = 1; e <= 2 * N + 2; e++) begin
            tick();
            if (e == 5) begin
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        zv[r][c] = 255;
            end
            if (e <= 2 * N + 1) begin
                busy_cnt += int'(busy);
                done_cnt += int'(done);
            end
        end
        chk("t6_busy_cycles", busy_cnt, 2 * N + 1);
        chk("t6_done_cycles", done_cnt, 1);
        chk("t6_reaccept", int'(busy), 1);
        clear_exp();
        expv[2][2] = 255;
        expv[2][3] = 255;
        chk_edges("t6a");
        enable = 1'b0;
        begin
            int cyc = 0;
            while (done !== 1'b1 && cyc < 200) begin
                tick();
                cyc++;
            end
            chk("t6_second_lat", cyc, 2 * N);
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                expv[r][c] = 255;
        chk_edges("t6b");
        tick();
        chk("t6_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
